// File: rtl/axi_lb_pkg.sv
// Shared types and helpers for the AXI4-Lite to local-bus bridge.
// FSM encoding, AXI response codes and the word-alignment helper.
package axi_lb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LB_WAIT = 2'd1,
        ST_RESP    = 2'd2
    } lb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Clears the byte-offset bits below the data-word size (dw in bits).
    function automatic logic [63:0] word_align(input logic [63:0] addr, input int dw);
        logic [63:0] mask;
        mask = 64'(dw / 8) - 64'd1;
        return addr & ~mask;
    endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bundle with slave (s) and master (m) views.
interface axi4_lite_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    logic            awvalid;
    logic            awready;
    logic [AW-1:0]   awaddr;
    logic [2:0]      awprot;
    logic            wvalid;
    logic            wready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            bvalid;
    logic            bready;
    logic [1:0]      bresp;
    logic            arvalid;
    logic            arready;
    logic [AW-1:0]   araddr;
    logic [2:0]      arprot;
    logic            rvalid;
    logic            rready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;

    modport s (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport m (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_lb_timeout.sv
// Access watchdog: load restarts at 1 (the first wait cycle), en counts up,
// expired flags the cycle in which TIMEOUT wait cycles have elapsed.
module axi_lb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = CW'(1);
        end else if (en) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = en && (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/axi4_lite_lb_bridge.sv
// AXI4-Lite slave to single-master local register bus bridge.
// One write and one read may be held; a single local access is in flight at a time.
module axi4_lite_lb_bridge
    import axi_lb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    axi4_lite_if.s          bus,
    output logic            lb_req,
    output logic            lb_we,
    output logic [AW-1:0]   lb_addr,
    output logic [DW-1:0]   lb_wdata,
    output logic [DW/8-1:0] lb_wstrb,
    input  logic            lb_ack,
    input  logic            lb_err,
    input  logic [DW-1:0]   lb_rdata
);
    localparam int SW = DW / 8;

    lb_state_t       state_q, state_d;
    logic            rdy_en_q, rdy_en_d;
    logic            aw_full_q, aw_full_d;
    logic            w_full_q, w_full_d;
    logic            ar_full_q, ar_full_d;
    logic [AW-1:0]   aw_addr_q, aw_addr_d;
    logic [AW-1:0]   ar_addr_q, ar_addr_d;
    logic [DW-1:0]   w_data_q, w_data_d;
    logic [SW-1:0]   w_strb_q, w_strb_d;
    logic            last_wr_q, last_wr_d;
    logic            lb_req_q, lb_req_d;
    logic            lb_we_q, lb_we_d;
    logic [AW-1:0]   lb_addr_q, lb_addr_d;
    logic [DW-1:0]   lb_wdata_q, lb_wdata_d;
    logic [SW-1:0]   lb_wstrb_q, lb_wstrb_d;
    logic            bvalid_q, bvalid_d;
    logic [1:0]      bresp_q, bresp_d;
    logic            rvalid_q, rvalid_d;
    logic [1:0]      rresp_q, rresp_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            aw_hs, w_hs, ar_hs;
    logic            wr_pend, rd_pend, grant_wr;
    logic            tmr_load, tmr_en, tmr_expired;
    logic            acc_done;
    logic [1:0]      acc_resp;
    logic [DW-1:0]   acc_rdata;
    logic [AW-1:0]   sel_addr;

    // Protection attributes carry no meaning on the local bus.
    logic unused_prot;
    assign unused_prot = ^{bus.awprot, bus.arprot};

    assign bus.awready = rdy_en_q && !aw_full_q;
    assign bus.wready  = rdy_en_q && !w_full_q;
    assign bus.arready = rdy_en_q && !ar_full_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rresp   = rresp_q;
    assign bus.rdata   = rdata_q;

    assign lb_req   = lb_req_q;
    assign lb_we    = lb_we_q;
    assign lb_addr  = lb_addr_q;
    assign lb_wdata = lb_wdata_q;
    assign lb_wstrb = lb_wstrb_q;

    assign aw_hs   = bus.awvalid && bus.awready;
    assign w_hs    = bus.wvalid && bus.wready;
    assign ar_hs   = bus.arvalid && bus.arready;
    assign wr_pend = aw_full_q && w_full_q;
    assign rd_pend = ar_full_q;

    // last_wr only moves on contested grants, so simultaneous pairs alternate starting with read.
    assign grant_wr = wr_pend && (!rd_pend || !last_wr_q);
    assign sel_addr = grant_wr ? aw_addr_q : ar_addr_q;

    axi_lb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        rdy_en_d   = 1'b1;
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        ar_full_d  = ar_full_q;
        aw_addr_d  = aw_addr_q;
        ar_addr_d  = ar_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        last_wr_d  = last_wr_q;
        lb_req_d   = lb_req_q;
        lb_we_d    = lb_we_q;
        lb_addr_d  = lb_addr_q;
        lb_wdata_d = lb_wdata_q;
        lb_wstrb_d = lb_wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        acc_done   = 1'b0;
        acc_resp   = RESP_SLVERR;
        acc_rdata  = '0;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = bus.awaddr;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = bus.wdata;
            w_strb_d = bus.wstrb;
        end
        if (ar_hs) begin
            ar_full_d = 1'b1;
            ar_addr_d = bus.araddr;
        end

        case (state_q)
            ST_IDLE: begin
                if (wr_pend || rd_pend) begin
                    if (wr_pend && rd_pend) begin
                        last_wr_d = grant_wr;
                    end
                    lb_req_d   = 1'b1;
                    lb_we_d    = grant_wr;
                    lb_addr_d  = AW'(word_align(64'(sel_addr), DW));
                    lb_wdata_d = grant_wr ? w_data_q : '0;
                    lb_wstrb_d = grant_wr ? w_strb_q : '0;
                    tmr_load   = 1'b1;
                    state_d    = ST_LB_WAIT;
                end
            end
            ST_LB_WAIT: begin
                tmr_en = 1'b1;
                // An ack in the expiry cycle still completes the access normally.
                if (lb_req_q && lb_ack) begin
                    acc_done  = 1'b1;
                    acc_resp  = lb_err ? RESP_SLVERR : RESP_OKAY;
                    acc_rdata = lb_rdata;
                end else if (tmr_expired) begin
                    acc_done  = 1'b1;
                end
                if (acc_done) begin
                    lb_req_d = 1'b0;
                    state_d  = ST_RESP;
                    if (lb_we_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = acc_resp;
                    end else begin
                        rvalid_d = 1'b1;
                        rresp_d  = acc_resp;
                        rdata_d  = acc_rdata;
                    end
                end
            end
            ST_RESP: begin
                if (lb_we_q) begin
                    if (bus.bready) begin
                        bvalid_d  = 1'b0;
                        aw_full_d = 1'b0;
                        w_full_d  = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end else if (bus.rready) begin
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rdy_en_q   <= 1'b0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            ar_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            ar_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            last_wr_q  <= 1'b1;
            lb_req_q   <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_addr_q  <= '0;
            lb_wdata_q <= '0;
            lb_wstrb_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            rdy_en_q   <= rdy_en_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            ar_full_q  <= ar_full_d;
            aw_addr_q  <= aw_addr_d;
            ar_addr_q  <= ar_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            last_wr_q  <= last_wr_d;
            lb_req_q   <= lb_req_d;
            lb_we_q    <= lb_we_d;
            lb_addr_q  <= lb_addr_d;
            lb_wdata_q <= lb_wdata_d;
            lb_wstrb_q <= lb_wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_lb_bridge.sv
// Scoreboard bench for axi4_lite_lb_bridge: stimulus pushes expected local accesses and
// B/R responses into queues; monitors pop and compare as the DUT presents them.
module tb_axi4_lite_lb_bridge;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int TO = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  strb;
        logic [63:0] wdata;
        int          len;
    } lb_exp_t;

    typedef struct {
        int          delay;
        logic        err;
        logic [63:0] rdata;
    } plan_t;

    typedef struct {
        logic [1:0]  resp;
        logic [63:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lb_req, lb_we;
    logic [31:0] lb_addr;
    logic [63:0] lb_wdata;
    logic [7:0]  lb_wstrb;
    logic        lb_ack, lb_err;
    logic [63:0] lb_rdata;
    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    lb_exp_t lb_q[$];
    plan_t   plan_q[$];
    rsp_t    b_q[$];
    rsp_t    r_q[$];

    axi4_lite_if #(.AW(AW), .DW(DW)) bus_if ();

    assign lb_ack = resp_ack | stray_ack;

    axi4_lite_lb_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus_if),
        .lb_req   (lb_req),
        .lb_we    (lb_we),
        .lb_addr  (lb_addr),
        .lb_wdata (lb_wdata),
        .lb_wstrb (lb_wstrb),
        .lb_ack   (lb_ack),
        .lb_err   (lb_err),
        .lb_rdata (lb_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Local-bus slave model: acks each access per the next plan entry (delay<0 = never).
    initial begin
        plan_t p;
        lb_err = 1'b0;
        lb_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (lb_req && !rst) begin
                if (plan_q.size() == 0) p = '{-1, 1'b0, 64'h0};
                else p = plan_q.pop_front();
                if (p.delay >= 0) begin
                    repeat (p.delay) @(posedge clk);
                    #1;
                    resp_ack = 1'b1;
                    lb_err   = p.err;
                    lb_rdata = p.rdata;
                    @(posedge clk); #1;
                    resp_ack = 1'b0;
                    lb_err   = 1'b0;
                end else begin
                    for (int i = 0; i < 100 && lb_req; i++) begin
                        @(posedge clk); #1;
                    end
                end
            end
        end
    end

    // Local-bus monitor: access attributes on lb_req rise, request length on fall.
    initial begin
        bit      in_acc = 0;
        int      len = 0;
        lb_exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_acc = 0;
            end else if (lb_req && !in_acc) begin
                in_acc = 1;
                len = 1;
                if (lb_q.size() == 0) begin
                    fail_msg("lb_unexpected_req");
                    e = '{1'b0, 32'h0, 8'h0, 64'h0, -1};
                end else begin
                    e = lb_q.pop_front();
                    check("lb_we", 64'(lb_we), 64'(e.we));
                    check("lb_addr", 64'(lb_addr), 64'(e.addr));
                    check("lb_wstrb", 64'(lb_wstrb), 64'(e.strb));
                    check("lb_wdata", lb_wdata, e.wdata);
                end
            end else if (lb_req && in_acc) begin
                len++;
            end else if (!lb_req && in_acc) begin
                in_acc = 0;
                if (e.len >= 0) check("lb_req_len", 64'(len), 64'(e.len));
            end
        end
    end

    // B channel monitor.
    initial begin
        bit         hold = 0;
        logic [1:0] prev = '0;
        rsp_t       e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (hold) begin
                    check("bvalid_stable", 64'(bus_if.bvalid), 64'd1);
                    check("bresp_stable", 64'(bus_if.bresp), 64'(prev));
                end
                if (bus_if.bvalid && bus_if.bready) begin
                    if (b_q.size() == 0) fail_msg("b_unexpected");
                    else begin
                        e = b_q.pop_front();
                        check("bresp", 64'(bus_if.bresp), 64'(e.resp));
                    end
                end
                hold = bus_if.bvalid && !bus_if.bready;
                prev = bus_if.bresp;
            end
        end
    end

    // R channel monitor.
    initial begin
        bit          hold = 0;
        logic [1:0]  prevr = '0;
        logic [63:0] prevd = '0;
        rsp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (hold) begin
                    check("rvalid_stable", 64'(bus_if.rvalid), 64'd1);
                    check("rresp_stable", 64'(bus_if.rresp), 64'(prevr));
                    check("rdata_stable", bus_if.rdata, prevd);
                end
                if (bus_if.rvalid && bus_if.rready) begin
                    if (r_q.size() == 0) fail_msg("r_unexpected");
                    else begin
                        e = r_q.pop_front();
                        check("rresp", 64'(bus_if.rresp), 64'(e.resp));
                        check("rdata", bus_if.rdata, e.data);
                    end
                end
                hold = bus_if.rvalid && !bus_if.rready;
                prevr = bus_if.rresp;
                prevd = bus_if.rdata;
            end
        end
    end

    task automatic do_aw(input logic [31:0] a);
        bit hs = 0;
        bus_if.awaddr = a;
        bus_if.awvalid = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clk);
            hs = bus_if.awready;
            @(posedge clk); #1;
        end
        bus_if.awvalid = 1'b0;
        if (!hs) fail_msg("aw_handshake_timeout");
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] s);
        bit hs = 0;
        bus_if.wdata = d;
        bus_if.wstrb = s;
        bus_if.wvalid = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clk);
            hs = bus_if.wready;
            @(posedge clk); #1;
        end
        bus_if.wvalid = 1'b0;
        if (!hs) fail_msg("w_handshake_timeout");
    endtask

    task automatic do_ar(input logic [31:0] a);
        bit hs = 0;
        bus_if.araddr = a;
        bus_if.arvalid = 1'b1;
        for (int i = 0; i < 200 && !hs; i++) begin
            @(negedge clk);
            hs = bus_if.arready;
            @(posedge clk); #1;
        end
        bus_if.arvalid = 1'b0;
        if (!hs) fail_msg("ar_handshake_timeout");
    endtask

    // which: 0=bvalid 1=rvalid 2=lb_req
    task automatic wait_high(input int which, input string name);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            case (which)
                0: seen = bus_if.bvalid;
                1: seen = bus_if.rvalid;
                default: seen = lb_req;
            endcase
        end
        if (!seen) fail_msg(name);
    endtask

    task automatic wait_idle(input string name);
        bit idle = 0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(posedge clk); #1;
            idle = (lb_q.size() == 0) && (b_q.size() == 0) && (r_q.size() == 0) &&
                   !lb_req && !bus_if.bvalid && !bus_if.rvalid;
        end
        if (!idle) fail_msg(name);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.awvalid = 0; bus_if.awaddr = '0; bus_if.awprot = '0;
        bus_if.wvalid = 0; bus_if.wdata = '0; bus_if.wstrb = '0;
        bus_if.arvalid = 0; bus_if.araddr = '0; bus_if.arprot = '0;
        bus_if.bready = 1; bus_if.rready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 64'(bus_if.awready), 64'd0);
        check("rst_bvalid", 64'(bus_if.bvalid), 64'd0);
        check("rst_rvalid", 64'(bus_if.rvalid), 64'd0);
        check("rst_lb_req", 64'(lb_req), 64'd0);
        check("rst_lb_addr", 64'(lb_addr), 64'd0);
        check("rst_rdata", bus_if.rdata, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_cycle_awready", 64'(bus_if.awready), 64'd0);
        @(posedge clk); #1;
        check("awready_after_rst", 64'(bus_if.awready), 64'd1);
        check("wready_after_rst", 64'(bus_if.wready), 64'd1);
        check("arready_after_rst", 64'(bus_if.arready), 64'd1);

        // 1: AW then W three cycles later, ack after 2 cycles, bready held low
        bus_if.bready = 0;
        lb_q.push_back('{1'b1, 32'h1000, 8'hFF, 64'hDEAD_BEEF_0000_0001, 3});
        plan_q.push_back('{2, 1'b0, 64'h0});
        b_q.push_back('{2'b00, 64'h0});
        fork
            do_aw(32'h1004);
            begin repeat (3) @(posedge clk); #1; do_w(64'hDEAD_BEEF_0000_0001, 8'hFF); end
        join
        wait_high(0, "t1_bvalid_timeout");
        repeat (3) @(posedge clk);
        #1;
        bus_if.bready = 1;
        wait_idle("t1_idle_timeout");

        // 2: read with rready low for 5 cycles
        bus_if.rready = 0;
        lb_q.push_back('{1'b0, 32'h20, 8'h00, 64'h0, 2});
        plan_q.push_back('{1, 1'b0, 64'h1122_3344_5566_7788});
        r_q.push_back('{2'b00, 64'h1122_3344_5566_7788});
        do_ar(32'h20);
        wait_high(1, "t2_rvalid_timeout");
        repeat (5) @(posedge clk);
        #1;
        bus_if.rready = 1;
        wait_idle("t2_idle_timeout");

        // 3a: write and read together -> read granted first
        lb_q.push_back('{1'b0, 32'h200, 8'h00, 64'h0, 1});
        lb_q.push_back('{1'b1, 32'h100, 8'h0F, 64'h0000_0000_0000_000A, 1});
        plan_q.push_back('{0, 1'b0, 64'h55});
        plan_q.push_back('{0, 1'b0, 64'h0});
        r_q.push_back('{2'b00, 64'h55});
        b_q.push_back('{2'b00, 64'h0});
        fork
            do_aw(32'h100);
            do_w(64'h0000_0000_0000_000A, 8'h0F);
            do_ar(32'h200);
        join
        wait_idle("t3a_idle_timeout");

        // 3b: second simultaneous pair -> write granted first; unaligned addresses
        lb_q.push_back('{1'b1, 32'h308, 8'hF0, 64'h0000_000B_0000_0000, 1});
        lb_q.push_back('{1'b0, 32'h400, 8'h00, 64'h0, 1});
        plan_q.push_back('{0, 1'b0, 64'h0});
        plan_q.push_back('{0, 1'b0, 64'h66});
        b_q.push_back('{2'b00, 64'h0});
        r_q.push_back('{2'b00, 64'h66});
        fork
            do_aw(32'h30F);
            do_w(64'h0000_000B_0000_0000, 8'hF0);
            do_ar(32'h404);
        join
        wait_idle("t3b_idle_timeout");

        // 4: timeouts on write and read; then ack landing in the expiry cycle
        lb_q.push_back('{1'b1, 32'h40, 8'h01, 64'h77, TO});
        plan_q.push_back('{-1, 1'b0, 64'h0});
        b_q.push_back('{2'b10, 64'h0});
        fork
            do_aw(32'h40);
            do_w(64'h77, 8'h01);
        join
        wait_idle("t4w_idle_timeout");
        lb_q.push_back('{1'b0, 32'h48, 8'h00, 64'h0, TO});
        plan_q.push_back('{-1, 1'b0, 64'h0});
        r_q.push_back('{2'b10, 64'h0});
        do_ar(32'h48);
        wait_idle("t4r_idle_timeout");
        lb_q.push_back('{1'b1, 32'h50, 8'h80, 64'h99, TO});
        plan_q.push_back('{TO - 1, 1'b0, 64'h0});
        b_q.push_back('{2'b00, 64'h0});
        fork
            do_aw(32'h50);
            do_w(64'h99, 8'h80);
        join
        wait_idle("t4a_idle_timeout");

        // 5: read acked with error; stray ack while idle
        lb_q.push_back('{1'b0, 32'h60, 8'h00, 64'h0, 1});
        plan_q.push_back('{0, 1'b1, 64'hCAFE});
        r_q.push_back('{2'b10, 64'hCAFE});
        do_ar(32'h60);
        wait_idle("t5_idle_timeout");
        stray_ack = 1'b1;
        @(posedge clk); #1;
        stray_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stray_lb_req", 64'(lb_req), 64'd0);
        check("stray_bvalid", 64'(bus_if.bvalid), 64'd0);
        check("stray_rvalid", 64'(bus_if.rvalid), 64'd0);

        // 6: reset while waiting for ack
        lb_q.push_back('{1'b1, 32'h70, 8'hFF, 64'h1234, -1});
        plan_q.push_back('{-1, 1'b0, 64'h0});
        fork
            do_aw(32'h70);
            do_w(64'h1234, 8'hFF);
        join
        wait_high(2, "t6_lb_req_timeout");
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("rst_mid_lb_req", 64'(lb_req), 64'd0);
        check("rst_mid_bvalid", 64'(bus_if.bvalid), 64'd0);
        check("rst_mid_rvalid", 64'(bus_if.rvalid), 64'd0);
        check("rst_mid_rdata", bus_if.rdata, 64'd0);
        check("rst_mid_awready", 64'(bus_if.awready), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rel_first_awready", 64'(bus_if.awready), 64'd0);
        @(posedge clk); #1;
        check("rel_awready", 64'(bus_if.awready), 64'd1);
        check("rel_wready", 64'(bus_if.wready), 64'd1);
        check("rel_arready", 64'(bus_if.arready), 64'd1);
        check("rel_lb_req", 64'(lb_req), 64'd0);

        // Bridge still works after reset
        lb_q.push_back('{1'b0, 32'h80, 8'h00, 64'h0, 1});
        plan_q.push_back('{0, 1'b0, 64'hABCD});
        r_q.push_back('{2'b00, 64'hABCD});
        do_ar(32'h80);
        wait_idle("t6_post_idle_timeout");

        check("lb_q_drained", 64'(lb_q.size()), 64'd0);
        check("b_q_drained", 64'(b_q.size()), 64'd0);
        check("r_q_drained", 64'(r_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
